// File: rtl/cdb_arbiter_pkg.sv
// Core parameters and the broadcast record shared by the CDB arbiter,
// the reorder buffer and the reservation stations.
package cdb_arbiter_pkg;

   localparam int NUM_FU = 8;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 8;
   localparam int IDX_W  = $clog2(NUM_FU);
   localparam int CNT_W  = $clog2(NUM_FU) + 1;

   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   // Slot 0 is the "no producer" tag and never holds a result.
   localparam logic [NUM_FU-1:0] SLOT_MASK = {{(NUM_FU-1){1'b1}}, 1'b0};

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
      logic              branch_fail;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit handshake and CDB broadcast bundle.
// The slave side is the arbiter; the master side is the producers and consumers.
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic [NUM_FU-1:0]        fu_valid;
   logic [NUM_FU*DATA_W-1:0] fu_result;
   logic [NUM_FU-1:0]        fu_branch_fail;
   logic [NUM_FU-1:0]        fu_ready;
   logic                     flush;
   logic                     cdb_valid;
   logic [TAG_W-1:0]         cdb_tag;
   logic [DATA_W-1:0]        cdb_value;
   logic                     cdb_branch_fail;
   logic [CNT_W-1:0]         held_count;

   modport master (
      output fu_valid, fu_result, fu_branch_fail, flush,
      input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_branch_fail, held_count
   );

   modport slave (
      input  fu_valid, fu_result, fu_branch_fail, flush,
      output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_branch_fail, held_count
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotating-priority picker: first full slot after rr_ptr, wrapping
// from NUM_FU-1 back to 1 and never selecting slot 0.
module cdb_rr_picker
   import cdb_arbiter_pkg::*;
(
   input  logic [NUM_FU-1:0] full,
   input  logic [TAG_W-1:0]  rr_ptr,
   output logic [NUM_FU-1:0] grant,
   output logic [TAG_W-1:0]  winner,
   output logic              any_grant
);

   int idx;

   always_comb begin
      grant     = '0;
      winner    = TAG_NONE;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 1; k < NUM_FU; k++) begin
         // rr_ptr + k never exceeds 2*(NUM_FU-1), so one subtraction wraps it.
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_FU) begin
            idx = idx - (NUM_FU - 1);
         end
         if (!any_grant && full[idx]) begin
            any_grant   = 1'b1;
            grant[idx]  = 1'b1;
            winner      = idx[TAG_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus broadcaster: one holding slot per functional unit and a
// registered round-robin broadcast of at most one result per cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input  logic         CLOCK_50,
   input  logic         RSTN_N,
   cdb_arbiter_if.slave bus
);

   logic [NUM_FU-1:0] full_q, full_d;
   logic [DATA_W-1:0] value_q [NUM_FU];
   logic [DATA_W-1:0] value_d [NUM_FU];
   logic [NUM_FU-1:0] bf_q, bf_d;
   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   cdb_t              cdb_q, cdb_d;
   logic [CNT_W-1:0]  held_count_q, held_count_d;

   logic [NUM_FU-1:0] grant;
   logic [NUM_FU-1:0] ready;
   logic [NUM_FU-1:0] accept;
   logic [TAG_W-1:0]  winner;
   logic              any_grant;

   cdb_rr_picker u_picker (
      .full      (full_q),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .winner    (winner),
      .any_grant (any_grant)
   );

   // A slot being drained this cycle can refill on the same edge.
   assign ready       = (~full_q | grant) & SLOT_MASK;
   assign accept      = bus.fu_valid & ready;
   assign bus.fu_ready = ready;

   always_comb begin
      full_d       = full_q;
      value_d      = value_q;
      bf_d         = bf_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_d        = '0;
      held_count_d = '0;

      if (bus.flush) begin
         full_d = '0;
      end else begin
         if (any_grant) begin
            cdb_d.valid       = 1'b1;
            cdb_d.tag         = winner;
            cdb_d.value       = value_q[winner[IDX_W-1:0]];
            cdb_d.branch_fail = bf_q[winner[IDX_W-1:0]];
            full_d            = full_q & ~grant;
            rr_ptr_d          = winner;
         end
         for (int l = 0; l < NUM_FU; l++) begin
            if (accept[l]) begin
               full_d[l]  = 1'b1;
               value_d[l] = bus.fu_result[l*DATA_W +: DATA_W];
               bf_d[l]    = bus.fu_branch_fail[l];
            end
         end
      end

      for (int l = 0; l < NUM_FU; l++) begin
         held_count_d = held_count_d + CNT_W'(full_d[l]);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
      if (!RSTN_N) begin
         full_q       <= '0;
         bf_q         <= '0;
         rr_ptr_q     <= TAG_NONE;
         cdb_q        <= '0;
         held_count_q <= '0;
         for (int l = 0; l < NUM_FU; l++) begin
            value_q[l] <= '0;
         end
      end else begin
         full_q       <= full_d;
         bf_q         <= bf_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_q        <= cdb_d;
         held_count_q <= held_count_d;
         for (int l = 0; l < NUM_FU; l++) begin
            value_q[l] <= value_d[l];
         end
      end
   end

   assign bus.cdb_valid       = cdb_q.valid;
   assign bus.cdb_tag         = cdb_q.tag;
   assign bus.cdb_value       = cdb_q.value;
   assign bus.cdb_branch_fail = cdb_q.branch_fail;
   assign bus.held_count      = held_count_q;

endmodule
